dma_rd_sched: RTL and testbench
===============================

DMA_RD_SCHED -- requirements
Module: dma_rd_sched

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 16, maximum read requests in flight (power of two, 2..64).
REQ-002 SHALL have parameter LEN_W, default 16, width of line count and line index.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous reset, asserted low.
REQ-006 SHALL have port cfg_base_addr  in  64  host byte address of buffer; bits [5:0] ignored.
REQ-007 SHALL have port cfg_num_lines  in  LEN_W  number of 64-byte lines to read.
REQ-008 SHALL have port start  in  1  single-cycle launch pulse.
REQ-009 SHALL have port abort  in  1  single-cycle stop pulse.
REQ-010 SHALL have port c0_alm_full  in  1  host read channel almost-full.
REQ-011 SHALL have port rd_req_valid  out  1  read request issued this cycle.
REQ-012 SHALL have port rd_req_addr  out  42  cache-line address (byte address >> 6).
REQ-013 SHALL have port rd_req_mdata  out  LEN_W  line index tag of request.
REQ-014 SHALL have port rd_rsp_valid  in  1  read response present.
REQ-015 SHALL have port rd_rsp_mdata  in  LEN_W  returned tag.
REQ-016 SHALL have port rd_rsp_data  in  512  returned line.
REQ-017 SHALL have port line_valid / line_idx / line_data  out  1 / LEN_W / 512  delivered line.
REQ-018 SHALL have port busy, done, err  out  1 each  status.
REQ-019 SHALL have port outstanding  out  $clog2(MAX_OUTSTANDING)+1  in-flight count.

Function
REQ-020 SHALL implement FSM states IDLE, ISSUE, DRAIN, DONE.
REQ-021 SHALL, on start in IDLE or DONE, latch cfg_base_addr[47:6] and cfg_num_lines, clear done/err, reset issue index to 0, enter ISSUE.
REQ-022 SHALL ignore start while in ISSUE or DRAIN.
REQ-023 SHALL go ISSUE->DONE directly when latched count is 0, issuing nothing.
REQ-024 SHALL, in ISSUE, assert rd_req_valid for one cycle per request iff c0_alm_full=0 and outstanding<MAX_OUTSTANDING, all outputs registered.
REQ-025 SHALL drive rd_req_addr = base_line + index modulo 2^42 (wraps silently) and rd_req_mdata = index.
REQ-026 SHALL enter DRAIN the cycle after the last index (count-1) is issued.
REQ-027 SHALL leave DRAIN for DONE when outstanding is 0 and no response is arriving.
REQ-028 SHALL increment outstanding on request, decrement on accepted response, hold it when both occur in one cycle.
REQ-029 SHALL accept responses in any order; line_valid/line_idx/line_data SHALL equal rd_rsp_valid/mdata/data delayed exactly one cycle.
REQ-030 SHALL, when rd_rsp_valid arrives with outstanding=0, set err sticky and neither forward the line nor decrement.
REQ-031 SHALL, on abort in ISSUE, stop issuing the same cycle and enter DRAIN; abort in other states SHALL be ignored.
REQ-032 SHALL hold busy=1 exactly in ISSUE and DRAIN; done=1 in DONE until next start.
REQ-033 SHALL stay in DONE until start; start in DONE behaves as REQ-021.

Reset
REQ-034 SHALL, on rst low, immediately force IDLE, outstanding=0, rd_req_valid=0, line_valid=0, busy=0, done=0, err=0, rd_req_addr=0, rd_req_mdata=0, line_idx=0, line_data=0.
REQ-035 SHALL, when reset occurs mid-transfer, discard all in-flight state; late responses after release SHALL set err.

Structure
REQ-036 SHALL place FSM state enum, line-address width (42) and line width (512) in the shared package dma_pkg.
REQ-037 SHALL be one module; the outstanding counter MAY be a sub-module named credit_counter.

Verification
REQ-038 SHALL test base=0x1000, lines=4, immediate in-order responses -> requests at line addresses 0x40..0x43, mdata 0..3, four line_valid pulses, done=1, err=0.
REQ-039 SHALL test MAX_OUTSTANDING=16, lines=40, responses withheld -> exactly 16 requests, then stall until responses return; all 40 delivered.
REQ-040 SHALL test c0_alm_full high for 10 cycles mid-ISSUE -> zero requests in that window, resumes at next index.
REQ-041 SHALL test abort after 3 issued of 8 -> no further requests, DONE after 3 responses, done=1.
REQ-042 SHALL test rsp with outstanding=0, and lines=0 start -> err=1 with no line_valid; DONE next cycle with no requests.
REQ-043 SHALL test base line 0x3FF_FFFF_FFFF, lines=2 -> addresses 0x3FF_FFFF_FFFF then 0x0.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and widths for the DMA read scheduler.
package dma_pkg;

   // Host read channel works in 64-byte cache lines addressed by byte address >> 6.
   localparam int LINE_ADDR_W = 42;
   localparam int LINE_W      = 512;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_DONE
   } state_t;

endpackage

// File: rtl/dma_rd_sched_credit_counter.sv
// Up/down counter tracking read requests in flight.
module credit_counter #(
   parameter int MAX_COUNT = 16,
   parameter int CNT_W     = $clog2(MAX_COUNT) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_inc,
   input  logic             i_dec,
   output logic [CNT_W-1:0] o_count
);

   logic [CNT_W-1:0] r_count;

   // Count up on a new request, down on an accepted response, hold when both happen together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (i_inc && !i_dec) begin
         r_count <= r_count + CNT_W'(1);
      end else if (!i_inc && i_dec) begin
         r_count <= r_count - CNT_W'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/dma_rd_sched.sv
// Issues a run of cache-line read requests to the host, limits requests in flight,
// and forwards returned lines (in any order) one cycle after they arrive.
module dma_rd_sched
   import dma_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 16,
   parameter int LEN_W           = 16
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [63:0]                          cfg_base_addr,
   input  logic [LEN_W-1:0]                     cfg_num_lines,
   input  logic                                 start,
   input  logic                                 abort,
   input  logic                                 c0_alm_full,
   output logic                                 rd_req_valid,
   output logic [LINE_ADDR_W-1:0]               rd_req_addr,
   output logic [LEN_W-1:0]                     rd_req_mdata,
   input  logic                                 rd_rsp_valid,
   input  logic [LEN_W-1:0]                     rd_rsp_mdata,
   input  logic [LINE_W-1:0]                    rd_rsp_data,
   output logic                                 line_valid,
   output logic [LEN_W-1:0]                     line_idx,
   output logic [LINE_W-1:0]                    line_data,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 err,
   output logic [$clog2(MAX_OUTSTANDING):0]     outstanding
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

   state_t                 r_state;
   state_t                 w_next;
   logic [LINE_ADDR_W-1:0] r_base_line;
   logic [LEN_W-1:0]       r_num_lines;
   logic [LEN_W-1:0]       r_idx;
   logic                   r_req_valid;
   logic [LINE_ADDR_W-1:0] r_req_addr;
   logic [LEN_W-1:0]       r_req_mdata;
   logic                   r_line_valid;
   logic [LEN_W-1:0]       r_line_idx;
   logic [LINE_W-1:0]      r_line_data;
   logic                   r_err;
   logic                   w_issue;
   logic                   w_start_ok;
   logic                   w_rsp_ok;
   logic                   w_stray;
   logic [CNT_W-1:0]       w_outstanding;
   logic                   w_unused;

   // Only the cache-line part of the byte address is meaningful to the host channel.
   assign w_unused = ^{cfg_base_addr[63:48], cfg_base_addr[5:0]};

   assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
   assign w_rsp_ok   = rd_rsp_valid && (w_outstanding != '0);
   assign w_stray    = rd_rsp_valid && (w_outstanding == '0);

   credit_counter #(
      .MAX_COUNT (MAX_OUTSTANDING),
      .CNT_W     (CNT_W)
   ) u_credit (
      .clk     (clk),
      .rst     (rst),
      .i_inc   (w_issue),
      .i_dec   (w_rsp_ok),
      .o_count (w_outstanding)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and issue decision; abort or back-pressure blocks the request in the same cycle.
   always_comb begin
      w_next  = r_state;
      w_issue = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               w_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            w_issue = !abort && !c0_alm_full && (w_outstanding < MAX_CNT) &&
                      (r_idx < r_num_lines);
            if (abort) begin
               w_next = ST_DRAIN;
            end else if (r_num_lines == '0) begin
               w_next = ST_DONE;
            end else if (w_issue && (r_idx == (r_num_lines - LEN_W'(1)))) begin
               w_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if ((w_outstanding == '0) && !rd_rsp_valid) begin
               w_next = ST_DONE;
            end
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // Job latch, request registers, response forwarding and sticky error.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_base_line  <= '0;
         r_num_lines  <= '0;
         r_idx        <= '0;
         r_req_valid  <= 1'b0;
         r_req_addr   <= '0;
         r_req_mdata  <= '0;
         r_line_valid <= 1'b0;
         r_line_idx   <= '0;
         r_line_data  <= '0;
         r_err        <= 1'b0;
      end else begin
         r_req_valid <= w_issue;
         if (w_start_ok) begin
            r_base_line <= cfg_base_addr[47:6];
            r_num_lines <= cfg_num_lines;
            r_idx       <= '0;
         end else if (w_issue) begin
            r_req_addr  <= r_base_line + LINE_ADDR_W'(r_idx);
            r_req_mdata <= r_idx;
            r_idx       <= r_idx + LEN_W'(1);
         end
         r_line_valid <= w_rsp_ok;
         if (w_rsp_ok) begin
            r_line_idx  <= rd_rsp_mdata;
            r_line_data <= rd_rsp_data;
         end
         if (w_stray) begin
            r_err <= 1'b1;
         end else if (w_start_ok) begin
            r_err <= 1'b0;
         end
      end
   end

   assign rd_req_valid = r_req_valid;
   assign rd_req_addr  = r_req_addr;
   assign rd_req_mdata = r_req_mdata;
   assign line_valid   = r_line_valid;
   assign line_idx     = r_line_idx;
   assign line_data    = r_line_data;
   assign busy         = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);
   assign done         = (r_state == ST_DONE);
   assign err          = r_err;
   assign outstanding  = w_outstanding;

endmodule

// File: tb/tb_dma_rd_sched.sv
// Scoreboard bench for dma_rd_sched: expected requests and lines are queued by the
// stimulus side, a monitor pops and compares whenever the DUT presents one.
module tb_dma_rd_sched;
   import dma_pkg::*;

   localparam int LEN_W = 16;
   localparam int MAXO  = 16;
   localparam int CNT_W = 5;

   typedef struct {
      logic [LINE_ADDR_W-1:0] addr;
      logic [LEN_W-1:0]       mdata;
   } reqExp_t;

   logic                   clk;
   logic                   rst;
   logic [63:0]            cfg_base_addr;
   logic [LEN_W-1:0]       cfg_num_lines;
   logic                   start;
   logic                   abort;
   logic                   c0_alm_full;
   logic                   rd_req_valid;
   logic [LINE_ADDR_W-1:0] rd_req_addr;
   logic [LEN_W-1:0]       rd_req_mdata;
   logic                   rd_rsp_valid = 1'b0;
   logic [LEN_W-1:0]       rd_rsp_mdata = '0;
   logic [LINE_W-1:0]      rd_rsp_data  = '0;
   logic                   line_valid;
   logic [LEN_W-1:0]       line_idx;
   logic [LINE_W-1:0]      line_data;
   logic                   busy;
   logic                   done;
   logic                   err;
   logic [CNT_W-1:0]       outstanding;

   reqExp_t          expReq[$];
   logic [LEN_W-1:0] expLine[$];
   logic [LEN_W-1:0] pend[$];

   int testsRun    = 0;
   int testsFailed = 0;
   int reqCount    = 0;
   int lineCount   = 0;
   int strayReq    = 0;
   int strayAck    = 0;
   bit rspEnable   = 1'b0;
   bit rspLifo     = 1'b0;

   dma_rd_sched #(
      .MAX_OUTSTANDING (MAXO),
      .LEN_W           (LEN_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .cfg_base_addr (cfg_base_addr),
      .cfg_num_lines (cfg_num_lines),
      .start         (start),
      .abort         (abort),
      .c0_alm_full   (c0_alm_full),
      .rd_req_valid  (rd_req_valid),
      .rd_req_addr   (rd_req_addr),
      .rd_req_mdata  (rd_req_mdata),
      .rd_rsp_valid  (rd_rsp_valid),
      .rd_rsp_mdata  (rd_rsp_mdata),
      .rd_rsp_data   (rd_rsp_data),
      .line_valid    (line_valid),
      .line_idx      (line_idx),
      .line_data     (line_data),
      .busy          (busy),
      .done          (done),
      .err           (err),
      .outstanding   (outstanding)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Line payload is a function of its tag so the monitor can predict it.
   function automatic logic [LINE_W-1:0] mkData(input logic [LEN_W-1:0] tag);
      return {16{tag, tag ^ 16'hA5C3}};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic pushReqs(input logic [LINE_ADDR_W-1:0] baseLine, input int n);
      reqExp_t e;
      for (int i = 0; i < n; i++) begin
         e.addr  = baseLine + LINE_ADDR_W'(i);
         e.mdata = LEN_W'(i);
         expReq.push_back(e);
      end
   endtask

   task automatic applyStimulus(input logic [63:0] base, input logic [LEN_W-1:0] lines);
      @(posedge clk);
      #1;
      cfg_base_addr = base;
      cfg_num_lines = lines;
      start         = 1'b1;
      reqCount      = 0;
      lineCount     = 0;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic waitDone(input int maxCycles, input string name);
      int n;
      n = 0;
      while ((done !== 1'b1) && (n < maxCycles)) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, 64'(done), 64'd1);
   endtask

   // Monitor: compare every presented request and delivered line against the scoreboard.
   always @(negedge clk) begin
      reqExp_t          e;
      logic [LEN_W-1:0] tag;
      if (rst) begin
         if (rd_req_valid) begin
            reqCount++;
            if (expReq.size() == 0) begin
               testsRun++;
               testsFailed++;
               $display("[TB] FAIL unexpectedReq: got addr 0x%0h mdata 0x%0h, expected no request",
                        rd_req_addr, rd_req_mdata);
            end else begin
               e = expReq.pop_front();
               checkOutput("reqAddr", 64'(rd_req_addr), 64'(e.addr));
               checkOutput("reqMdata", 64'(rd_req_mdata), 64'(e.mdata));
            end
         end
         if (line_valid) begin
            lineCount++;
            if (expLine.size() == 0) begin
               testsRun++;
               testsFailed++;
               $display("[TB] FAIL unexpectedLine: got idx 0x%0h, expected no line", line_idx);
            end else begin
               tag = expLine.pop_front();
               checkOutput("lineIdx", 64'(line_idx), 64'(tag));
               checkOutput("lineData", line_data[63:0] ^ 64'(line_data != mkData(tag)),
                           mkData(tag)[63:0]);
            end
         end
      end
   end

   // Host model: collects issued tags and answers them one per cycle when enabled.
   always begin
      logic [LEN_W-1:0] tag;
      @(negedge clk);
      if (!rst) begin
         pend.delete();
      end else if (rd_req_valid) begin
         pend.push_back(rd_req_mdata);
      end
      @(posedge clk);
      #1;
      if (strayReq != strayAck) begin
         strayAck     = strayReq;
         rd_rsp_valid = 1'b1;
         rd_rsp_mdata = 16'h0005;
         rd_rsp_data  = mkData(16'h0005);
      end else if (rspEnable && (pend.size() > 0)) begin
         tag          = rspLifo ? pend.pop_back() : pend.pop_front();
         rd_rsp_valid = 1'b1;
         rd_rsp_mdata = tag;
         rd_rsp_data  = mkData(tag);
         expLine.push_back(tag);
      end else begin
         rd_rsp_valid = 1'b0;
      end
   end

   // Hard stop so a wedged DUT still produces a verdict.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed test sequence.
   initial begin
      int  n0;
      bit  found;
      rst           = 1'b0;
      start         = 1'b0;
      abort         = 1'b0;
      c0_alm_full   = 1'b0;
      cfg_base_addr = '0;
      cfg_num_lines = '0;

      repeat (3) @(negedge clk);
      checkOutput("rstBusy", 64'(busy), 64'd0);
      checkOutput("rstDone", 64'(done), 64'd0);
      checkOutput("rstErr", 64'(err), 64'd0);
      checkOutput("rstReqValid", 64'(rd_req_valid), 64'd0);
      checkOutput("rstLineValid", 64'(line_valid), 64'd0);
      checkOutput("rstOutstanding", 64'(outstanding), 64'd0);
      checkOutput("rstReqAddr", 64'(rd_req_addr), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Four lines at 0x1000, immediate in-order responses.
      pushReqs(42'h40, 4);
      rspEnable = 1'b1;
      applyStimulus(64'h1000, 16'd4);
      waitDone(60, "t1Done");
      checkOutput("t1Lines", 64'(lineCount), 64'd4);
      checkOutput("t1Err", 64'(err), 64'd0);
      checkOutput("t1Busy", 64'(busy), 64'd0);
      checkOutput("t1Outstanding", 64'(outstanding), 64'd0);

      // Address wrap at the top of the line space; stray low/high address bits ignored.
      pushReqs(42'h3FF_FFFF_FFFF, 2);
      applyStimulus(64'hFFFF_FFFF_FFFF_FFE5, 16'd2);
      waitDone(40, "t2Done");
      checkOutput("t2Lines", 64'(lineCount), 64'd2);

      // Almost-full held for 10 cycles mid-issue.
      pushReqs(42'h1000, 12);
      applyStimulus(64'h40000, 16'd12);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (reqCount >= 4) break;
      end
      @(posedge clk);
      #1;
      c0_alm_full = 1'b1;
      @(negedge clk);
      #1;
      n0 = reqCount;
      repeat (10) @(posedge clk);
      #1;
      c0_alm_full = 1'b0;
      @(negedge clk);
      #1;
      checkOutput("t3AlmFullWindow", 64'(reqCount), 64'(n0));
      checkOutput("t3StillBusy", 64'(busy), 64'd1);
      waitDone(100, "t3Done");
      checkOutput("t3Lines", 64'(lineCount), 64'd12);

      // 40 lines with responses withheld: credit limit stalls at 16.
      rspEnable = 1'b0;
      pushReqs(42'h80, 40);
      applyStimulus(64'h2000, 16'd40);
      repeat (30) @(negedge clk);
      #1;
      checkOutput("t4ReqsAtLimit", 64'(reqCount), 64'd16);
      checkOutput("t4OutstandingAtLimit", 64'(outstanding), 64'd16);
      checkOutput("t4BusyStalled", 64'(busy), 64'd1);
      rspLifo   = 1'b1;
      rspEnable = 1'b1;
      waitDone(400, "t4Done");
      checkOutput("t4Lines", 64'(lineCount), 64'd40);
      checkOutput("t4Outstanding", 64'(outstanding), 64'd0);
      rspLifo = 1'b0;

      // Abort after the third of eight requests.
      rspEnable = 1'b0;
      pushReqs(42'h200, 3);
      applyStimulus(64'h8000, 16'd8);
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (rd_req_valid && (rd_req_mdata == 16'd2)) begin
            found = 1'b1;
            break;
         end
      end
      checkOutput("t5ThirdReqSeen", 64'(found), 64'd1);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      checkOutput("t5Reqs", 64'(reqCount), 64'd3);
      checkOutput("t5Outstanding", 64'(outstanding), 64'd3);
      checkOutput("t5DrainBusy", 64'(busy), 64'd1);
      checkOutput("t5NotDone", 64'(done), 64'd0);
      rspEnable = 1'b1;
      waitDone(50, "t5Done");
      checkOutput("t5Lines", 64'(lineCount), 64'd3);

      // Reset mid-transfer, then a late response must flag an error without a line.
      rspEnable = 1'b0;
      pushReqs(42'h40, 4);
      applyStimulus(64'h1000, 16'd4);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rd_req_valid && (rd_req_mdata == 16'd1)) break;
      end
      #2;
      rst = 1'b0;
      #1;
      checkOutput("t6RstOutstanding", 64'(outstanding), 64'd0);
      checkOutput("t6RstBusy", 64'(busy), 64'd0);
      checkOutput("t6RstReqValid", 64'(rd_req_valid), 64'd0);
      expReq.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      strayReq++;
      repeat (3) @(negedge clk);
      #1;
      checkOutput("t6StrayErr", 64'(err), 64'd1);
      checkOutput("t6StrayNoLine", 64'(lineCount), 64'd0);
      checkOutput("t6StayIdle", 64'(busy), 64'd0);

      // Zero-line job: straight to DONE, error cleared, nothing issued.
      applyStimulus(64'h1000, 16'd0);
      @(negedge clk);
      checkOutput("t7IssueBusy", 64'(busy), 64'd1);
      checkOutput("t7ErrCleared", 64'(err), 64'd0);
      @(negedge clk);
      checkOutput("t7Done", 64'(done), 64'd1);
      repeat (3) @(negedge clk);
      #1;
      checkOutput("t7NoReqs", 64'(reqCount), 64'd0);
      checkOutput("t7NoLines", 64'(lineCount), 64'd0);

      checkOutput("leftoverReqs", 64'(expReq.size()), 64'd0);
      checkOutput("leftoverLines", 64'(expLine.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
